// File: rtl/code_skid_pkg.sv
// Shared types and constants for the code skid stage and its optional code filter.
package code_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Codes the downstream decoder has explicit arms for.
  localparam int CODE_LEGAL_MIN = 1;
  localparam int CODE_LEGAL_MAX = 2;

  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/code_skid_stage_filter.sv
// code_filter: legality check on incoming selector codes plus a saturating drop counter.
// Only instantiated when CODE_SKID_FILTER_EN is defined.
module code_filter
  import code_skid_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_fire,
  input  logic [W-1:0]          code,
  output logic                  legal,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  always_comb begin
    legal = (int'(code) >= CODE_LEGAL_MIN) && (int'(code) <= CODE_LEGAL_MAX);
  end

  // Counts handshaken-but-discarded codes, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (in_fire && !legal && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/code_skid_stage.sv
// Two-entry registered skid stage feeding a registered selector x to the case decoder.
// Optional feature: define CODE_SKID_FILTER_EN to discard codes outside the legal set.
module code_skid_stage
  import code_skid_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [W-1:0]          in_code,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [W-1:0]          x,
  input  logic                  out_ready,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] skid;
  logic         in_fire, out_fire, store;
  logic         load_x, load_skid, skid_to_x;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

`ifdef CODE_SKID_FILTER_EN
  logic code_legal;

  code_filter #(.W(W)) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_fire  (in_fire),
    .code     (in_code),
    .legal    (code_legal),
    .drop_cnt (drop_cnt)
  );

  // A filtered code completes its handshake but never enters storage.
  assign store = in_fire & code_legal;
`else
  assign store    = in_fire;
  assign drop_cnt = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_x    = 1'b0;
    load_skid = 1'b0;
    skid_to_x = 1'b0;
    case (state_q)
      EMPTY: begin
        if (store) begin
          load_x  = 1'b1;
          state_d = ONE;
        end
      end
      ONE: begin
        if (store && !out_fire) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (!store && out_fire) begin
          state_d = EMPTY;
        end else if (store && out_fire) begin
          load_x = 1'b1;
        end
      end
      FULL: begin
        if (out_fire) begin
          skid_to_x = 1'b1;
          state_d   = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q != EMPTY);
  end

  // in_ready is registered from the next state so no combinational path reaches upstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b1;
      x        <= '0;
      skid     <= '0;
    end else begin
      in_ready <= (state_d != FULL);
      if (load_x) begin
        x <= in_code;
      end else if (skid_to_x) begin
        x <= skid;
      end
      if (load_skid) begin
        skid <= in_code;
      end
    end
  end

endmodule
